// File: rtl/iexu_sched_pkg.sv
// Shared types for the integer execution unit writeback scheduler.
package iexu_sched_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_BMU = 2'd1,
        WB_MUL = 2'd2,
        WB_DIV = 2'd3
    } wb_src_t;

    typedef struct packed {
        logic valid;
        logic is_mul;
    } resv_slot_t;

    localparam int MUL_LATENCY_DEFAULT = 9;

endpackage

// File: rtl/writeback_reservation_table.sv
// Shifting table of future writeback slots; slot[k] writes back k cycles from now.
module writeback_reservation_table
    import iexu_sched_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic bmu_wr_i,
    input  logic mul_wr_i,
    output logic slot0_valid_o,
    output logic slot0_is_mul_o,
    output logic slot1_valid_o,
    output logic any_valid_o
);

    // Writes land already shifted, so slot[MUL_LATENCY] never needs its own register.
    resv_slot_t [MUL_LATENCY-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (en_i) begin
            for (int k = 0; k < MUL_LATENCY - 1; k++) slot_d[k] = slot_q[k+1];
            slot_d[MUL_LATENCY-1] = '0;
            if (bmu_wr_i) slot_d[0] = '{valid: 1'b1, is_mul: 1'b0};
            if (mul_wr_i) slot_d[MUL_LATENCY-1] = '{valid: 1'b1, is_mul: 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) slot_q <= '0;
        else       slot_q <= slot_d;
    end

    always_comb begin
        any_valid_o = 1'b0;
        for (int k = 0; k < MUL_LATENCY; k++) any_valid_o = any_valid_o | slot_q[k].valid;
    end

    assign slot0_valid_o  = slot_q[0].valid;
    assign slot0_is_mul_o = slot_q[0].is_mul;
    assign slot1_valid_o  = slot_q[1].valid;

endmodule

// File: rtl/iexu_writeback_scheduler.sv
// Issue gating and shared-writeback arbitration for ALU/BMU/MUL/DIV.
module iexu_writeback_scheduler
    import iexu_sched_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clk_en_i,
    input  logic            issue_valid_i,
    input  logic [3:0]      issue_unit_i,
    output logic            issue_ready_o,
    output logic [3:0]      data_valid_o,
    input  logic            div_idle_i,
    input  logic            div_valid_i,
    input  logic [XLEN-1:0] div_result_i,
    output logic [3:0]      wb_sel_o,
    output logic            wb_div_buffered_o,
    output logic [XLEN-1:0] div_result_o,
    output logic            busy_o
);

    logic            slot0_valid, slot0_is_mul, slot1_valid, resv_any;
    logic            div_buf_q, div_buf_d;
    logic [XLEN-1:0] div_data_q, div_data_d;
    logic            div_pend_q, div_pend_d;
    logic            active, unit_onehot, accept;
    logic [3:0]      unit_rdy;

    // Combinational outputs must also read 0 while reset is held.
    assign active      = clk_en_i & ~rst_i;
    assign unit_onehot = (issue_unit_i != 4'b0) && ((issue_unit_i & (issue_unit_i - 4'd1)) == 4'b0);

    always_comb begin
        unit_rdy         = '0;
        unit_rdy[WB_ALU] = ~slot0_valid & ~div_buf_q & ~div_valid_i;
        unit_rdy[WB_BMU] = ~slot1_valid;
        unit_rdy[WB_MUL] = 1'b1;
        unit_rdy[WB_DIV] = div_idle_i & ~div_buf_q & ~div_valid_i;
    end

    assign issue_ready_o = active & unit_onehot & (|(issue_unit_i & unit_rdy));
    assign accept        = issue_valid_i & issue_ready_o;
    assign data_valid_o  = issue_unit_i & {4{accept}};

    writeback_reservation_table #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_resv (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (clk_en_i),
        .bmu_wr_i       (accept & issue_unit_i[WB_BMU]),
        .mul_wr_i       (accept & issue_unit_i[WB_MUL]),
        .slot0_valid_o  (slot0_valid),
        .slot0_is_mul_o (slot0_is_mul),
        .slot1_valid_o  (slot1_valid),
        .any_valid_o    (resv_any)
    );

    // Slot 0 priority: reservation > buffered DIV > direct DIV > ALU.
    always_comb begin
        wb_sel_o          = '0;
        wb_div_buffered_o = 1'b0;
        if (active) begin
            if (slot0_valid) begin
                if (slot0_is_mul) wb_sel_o[WB_MUL] = 1'b1;
                else              wb_sel_o[WB_BMU] = 1'b1;
            end else if (div_buf_q) begin
                wb_sel_o[WB_DIV]  = 1'b1;
                wb_div_buffered_o = 1'b1;
            end else if (div_valid_i) begin
                wb_sel_o[WB_DIV] = 1'b1;
            end else if (accept & issue_unit_i[WB_ALU]) begin
                wb_sel_o[WB_ALU] = 1'b1;
            end
        end
    end

    always_comb begin
        div_buf_d  = div_buf_q;
        div_data_d = div_data_q;
        div_pend_d = div_pend_q;
        if (clk_en_i) begin
            if (div_valid_i & (slot0_valid | div_buf_q)) begin
                div_buf_d  = 1'b1;
                div_data_d = div_result_i;
            end else if (div_buf_q & ~slot0_valid) begin
                div_buf_d = 1'b0;
            end
            if (accept & issue_unit_i[WB_DIV]) div_pend_d = 1'b1;
            else if (div_valid_i)              div_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_buf_q  <= 1'b0;
            div_data_q <= '0;
            div_pend_q <= 1'b0;
        end else begin
            div_buf_q  <= div_buf_d;
            div_data_q <= div_data_d;
            div_pend_q <= div_pend_d;
        end
    end

    assign div_result_o = div_data_q;
    assign busy_o       = ~rst_i & (resv_any | div_buf_q | div_pend_q);

endmodule
